// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester round-robin sequencer for the APB master bus port
module apb_req_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] rq_req,
  input  logic [1:0] rq_write,
  input  logic [1:0] rq_sel0,
  input  logic [1:0] rq_sel1,
  input  logic [7:0] rq_addr0,
  input  logic [7:0] rq_addr1,
  input  logic [7:0] rq_wdata0,
  input  logic [7:0] rq_wdata1,
  output logic [1:0] rq_done,
  output logic       rq_error,
  output logic [7:0] rq_rdata,
  output logic       busy,
  output logic       m_start,
  output logic       m_write,
  output logic [1:0] m_sel,
  output logic [7:0] m_addr,
  output logic [7:0] m_wdata,
  input  logic       m_ready,
  input  logic       m_error,
  input  logic [7:0] m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // Last counter value at which a missing m_ready still counts as a wait cycle
  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic       r_last_grant;
  logic       r_grant;
  logic [7:0] r_cnt;
  logic [1:0] r_rq_done;
  logic       r_rq_error;
  logic [7:0] r_rq_rdata;
  logic       r_busy;
  logic       r_m_start;
  logic       r_m_write;
  logic [1:0] r_m_sel;
  logic [7:0] r_m_addr;
  logic [7:0] r_m_wdata;

  logic       w_any_req;
  logic       w_win;
  logic       w_win_write;
  logic [1:0] w_win_sel;
  logic [7:0] w_win_addr;
  logic [7:0] w_win_wdata;
  logic       w_sel_ok;

  // Round-robin winner of the current requests and its transfer fields
  always_comb begin
    w_any_req   = |rq_req;
    w_win       = (rq_req == 2'b11) ? ~r_last_grant : rq_req[1];
    w_win_write = w_win ? rq_write[1] : rq_write[0];
    w_win_sel   = w_win ? rq_sel1     : rq_sel0;
    w_win_addr  = w_win ? rq_addr1    : rq_addr0;
    w_win_wdata = w_win ? rq_wdata1   : rq_wdata0;
    w_sel_ok    = (w_win_sel == 2'd1) || (w_win_sel == 2'd2);
  end

  // Sequencer: every output is registered on the edge that enters its state,
  // and the m_* registers double as the latch of the granted request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_cnt        <= 8'd0;
      r_rq_done    <= 2'b00;
      r_rq_error   <= 1'b0;
      r_rq_rdata   <= 8'd0;
      r_busy       <= 1'b0;
      r_m_start    <= 1'b0;
      r_m_write    <= 1'b0;
      r_m_sel      <= 2'd0;
      r_m_addr     <= 8'd0;
      r_m_wdata    <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant      <= w_win;
            r_last_grant <= w_win;
            r_busy       <= 1'b1;
            if (w_sel_ok) begin
              r_m_start <= 1'b1;
              r_m_write <= w_win_write;
              r_m_sel   <= w_win_sel;
              r_m_addr  <= w_win_addr;
              r_m_wdata <= w_win_wdata;
              r_state   <= S_ISSUE;
            end else begin
              // Unroutable select: answer at once without touching the bus
              r_rq_done  <= {w_win, ~w_win};
              r_rq_error <= 1'b1;
              r_rq_rdata <= 8'd0;
              r_state    <= S_RELEASE;
            end
          end
        end
        S_ISSUE: begin
          r_m_start <= 1'b0;
          r_cnt     <= 8'd0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (m_ready) begin
            r_rq_done  <= {r_grant, ~r_grant};
            r_rq_error <= m_error;
            r_rq_rdata <= r_m_write ? 8'd0 : m_rdata;
            r_m_sel    <= 2'd0;
            r_state    <= S_RELEASE;
          end else if (r_cnt == LP_WAIT_LAST) begin
            r_rq_done  <= {r_grant, ~r_grant};
            r_rq_error <= 1'b1;
            r_rq_rdata <= 8'd0;
            r_m_sel    <= 2'd0;
            r_state    <= S_RELEASE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RELEASE: begin
          r_rq_done  <= 2'b00;
          r_rq_error <= 1'b0;
          r_rq_rdata <= 8'd0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rq_done  = r_rq_done;
  assign rq_error = r_rq_error;
  assign rq_rdata = r_rq_rdata;
  assign busy     = r_busy;
  assign m_start  = r_m_start;
  assign m_write  = r_m_write;
  assign m_sel    = r_m_sel;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - vector table, directed sequences and random transfers against a transaction model
module tb_apb_req_arbiter;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] rq_req = 2'b00;
  logic [1:0] rq_write = 2'b00;
  logic [1:0] rq_sel0 = 2'd0;
  logic [1:0] rq_sel1 = 2'd0;
  logic [7:0] rq_addr0 = 8'd0;
  logic [7:0] rq_addr1 = 8'd0;
  logic [7:0] rq_wdata0 = 8'd0;
  logic [7:0] rq_wdata1 = 8'd0;
  logic [1:0] rq_done;
  logic       rq_error;
  logic [7:0] rq_rdata;
  logic       busy;
  logic       m_start;
  logic       m_write;
  logic [1:0] m_sel;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  logic       m_ready = 1'b0;
  logic       m_error = 1'b0;
  logic [7:0] m_rdata = 8'd0;

  apb_req_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .rq_req(rq_req), .rq_write(rq_write), .rq_sel0(rq_sel0), .rq_sel1(rq_sel1),
    .rq_addr0(rq_addr0), .rq_addr1(rq_addr1), .rq_wdata0(rq_wdata0), .rq_wdata1(rq_wdata1),
    .rq_done(rq_done), .rq_error(rq_error), .rq_rdata(rq_rdata), .busy(busy),
    .m_start(m_start), .m_write(m_write), .m_sel(m_sel), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_error(m_error), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Slave behaviour knobs and storage
  int       slv_wait = 0;
  bit       slv_err = 1'b0;
  bit       slv_spur = 1'b0;
  int       slv_cnt = -1;
  bit [7:0] slv_mem [4][256];

  // Reference model state
  bit [7:0] mdl_mem [4][256];
  bit       mdl_last = 1'b1;

  // Slave: answers slv_wait cycles into WAIT, optionally with a stray ready during the start cycle
  always @(negedge clk) begin
    m_ready = 1'b0;
    m_error = 1'b0;
    m_rdata = 8'h00;
    if (reset) begin
      slv_cnt = -1;
    end else if (m_start) begin
      slv_cnt = slv_wait;
      if (slv_spur) begin
        m_ready = 1'b1;
        m_error = 1'b1;
        m_rdata = 8'hC3;
      end
    end else if (m_sel == 2'd0) begin
      slv_cnt = -1;
    end else if (slv_cnt == 0) begin
      m_ready = 1'b1;
      m_error = slv_err;
      if (m_write) begin
        if (!slv_err) slv_mem[m_sel][m_addr] = m_wdata;
        m_rdata = 8'hA5;
      end else begin
        m_rdata = slv_mem[m_sel][m_addr];
      end
      slv_cnt = -1;
    end else if (slv_cnt > 0) begin
      slv_cnt = slv_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer starting from IDLE; lat = samples after the grant edge until rq_done
  task automatic run_xfer(input string name, input logic [1:0] req, input logic [1:0] wr,
                          input logic [1:0] s0, input logic [1:0] s1,
                          input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input int wt, input bit serr, input bit spur,
                          input bit ew, input bit ee, input logic [7:0] erd, input int lat);
    logic [1:0] selw;
    logic [7:0] addrw;
    logic [7:0] dataw;
    logic       wrw;
    bit         valid;
    selw  = ew ? s1 : s0;
    addrw = ew ? a1 : a0;
    dataw = ew ? d1 : d0;
    wrw   = ew ? wr[1] : wr[0];
    valid = (selw == 2'd1) || (selw == 2'd2);
    slv_wait = wt; slv_err = serr; slv_spur = spur;
    rq_req = req; rq_write = wr; rq_sel0 = s0; rq_sel1 = s1;
    rq_addr0 = a0; rq_addr1 = a1; rq_wdata0 = d0; rq_wdata1 = d1;
    for (int n = 0; n <= lat; n++) begin
      tick();
      if (n == 0) begin
        chk({name, " busy"}, 32'(busy), 1);
        chk({name, " m_start"}, 32'(m_start), 32'(valid));
        if (valid) begin
          chk({name, " m_sel"}, 32'(m_sel), 32'(selw));
          chk({name, " m_addr"}, 32'(m_addr), 32'(addrw));
          chk({name, " m_write"}, 32'(m_write), 32'(wrw));
          chk({name, " m_wdata"}, 32'(m_wdata), 32'(dataw));
        end
      end else if (valid && n < lat) begin
        chk({name, " wait m_start"}, 32'(m_start), 0);
        chk({name, " wait m_sel"}, 32'(m_sel), 32'(selw));
        chk({name, " wait m_addr"}, 32'(m_addr), 32'(addrw));
      end
      if (n < lat) begin
        chk({name, " early done"}, 32'(rq_done), 0);
      end else begin
        chk({name, " done"}, 32'(rq_done), ew ? 2 : 1);
        chk({name, " error"}, 32'(rq_error), 32'(ee));
        chk({name, " rdata"}, 32'(rq_rdata), 32'(erd));
        chk({name, " release m_sel"}, 32'(m_sel), 0);
      end
    end
    rq_req = 2'b00;
    tick();
    chk({name, " idle busy"}, 32'(busy), 0);
    chk({name, " idle done"}, 32'(rq_done), 0);
    for (int i = 0; i < 40 && busy; i++) tick();
    mdl_last = ew;
    if (valid && !ee && wrw) mdl_mem[selw][addrw] = dataw;
  endtask

  typedef struct {
    logic [1:0] req, wr, s0, s1;
    logic [7:0] a0, a1, d0, d1;
    int         wt;
    bit         serr, spur, ew, ee;
    logic [7:0] erd;
    int         lat;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int prev;
    //          req    wr     s0    s1    a0     a1     d0     d1     wt serr spur ew ee erd    lat
    tbl[0]  = '{2'b01, 2'b01, 2'd1, 2'd0, 8'h05, 8'h00, 8'h04, 8'h00, 0,  0,   0,   0, 0, 8'h00, 2};
    tbl[1]  = '{2'b10, 2'b10, 2'd0, 2'd1, 8'h00, 8'h06, 8'h00, 8'h5A, 2,  0,   1,   1, 0, 8'h00, 4};
    tbl[2]  = '{2'b10, 2'b00, 2'd0, 2'd1, 8'h00, 8'h06, 8'h00, 8'h00, 5,  0,   0,   1, 0, 8'h5A, 7};
    tbl[3]  = '{2'b01, 2'b00, 2'd1, 2'd0, 8'h05, 8'h00, 8'h00, 8'h00, 0,  0,   0,   0, 0, 8'h04, 2};
    tbl[4]  = '{2'b11, 2'b00, 2'd1, 2'd1, 8'h05, 8'h06, 8'h00, 8'h00, 1,  0,   0,   1, 0, 8'h5A, 3};
    tbl[5]  = '{2'b11, 2'b00, 2'd1, 2'd1, 8'h05, 8'h06, 8'h00, 8'h00, 0,  0,   0,   0, 0, 8'h04, 2};
    tbl[6]  = '{2'b01, 2'b00, 2'd0, 2'd1, 8'h05, 8'h00, 8'h00, 8'h00, 0,  0,   0,   0, 1, 8'h00, 0};
    tbl[7]  = '{2'b01, 2'b01, 2'd3, 2'd1, 8'h05, 8'h00, 8'h11, 8'h00, 0,  0,   0,   0, 1, 8'h00, 0};
    tbl[8]  = '{2'b10, 2'b00, 2'd1, 2'd2, 8'h00, 8'h10, 8'h00, 8'h00, 20, 0,   0,   1, 1, 8'h00, 9};
    tbl[9]  = '{2'b10, 2'b10, 2'd1, 2'd2, 8'h00, 8'h10, 8'h00, 8'h33, 3,  0,   0,   1, 0, 8'h00, 5};
    tbl[10] = '{2'b01, 2'b00, 2'd2, 2'd1, 8'h10, 8'h00, 8'h00, 8'h00, 7,  0,   0,   0, 0, 8'h33, 9};
    tbl[11] = '{2'b01, 2'b00, 2'd1, 2'd1, 8'h05, 8'h00, 8'h00, 8'h00, 0,  1,   0,   0, 1, 8'h04, 2};

    tick();
    tick();
    chk("reset rq_done", 32'(rq_done), 0);
    chk("reset rq_error", 32'(rq_error), 0);
    chk("reset rq_rdata", 32'(rq_rdata), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset m_start", 32'(m_start), 0);
    chk("reset m_sel", 32'(m_sel), 0);
    chk("reset m_addr", 32'(m_addr), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_xfer($sformatf("vec%0d", i), tbl[i].req, tbl[i].wr, tbl[i].s0, tbl[i].s1,
               tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, tbl[i].wt, tbl[i].serr,
               tbl[i].spur, tbl[i].ew, tbl[i].ee, tbl[i].erd, tbl[i].lat);
    end

    // Contention from reset: both held for four transfers
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mdl_last = 1'b1;
    slv_wait = 0; slv_err = 1'b0; slv_spur = 1'b0;
    rq_write = 2'b00; rq_sel0 = 2'd1; rq_sel1 = 2'd1; rq_addr0 = 8'h05; rq_addr1 = 8'h06;
    rq_req = 2'b11;
    k = 0;
    prev = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      tick();
      if (rq_done != 2'b00) begin
        chk("contend grant", 32'(rq_done), (k % 2 == 1) ? 2 : 1);
        chk("contend rdata", 32'(rq_rdata), (k % 2 == 1) ? 32'(mdl_mem[1][6]) : 32'(mdl_mem[1][5]));
        if (k > 0) chk("contend spacing", c - prev, 4);
        prev = c;
        k++;
      end
    end
    chk("contend count", k, 4);
    rq_req = 2'b00;
    tick();
    chk("contend idle busy", 32'(busy), 0);
    for (int i = 0; i < 40 && busy; i++) tick();
    mdl_last = 1'b1;

    // Reset during the third WAIT cycle of a requester-0 write
    slv_wait = 20; slv_err = 1'b0; slv_spur = 1'b0;
    rq_write = 2'b01; rq_sel0 = 2'd1; rq_addr0 = 8'h20; rq_wdata0 = 8'h77;
    rq_req = 2'b01;
    tick();
    tick();
    tick();
    tick();
    chk("rst pre busy", 32'(busy), 1);
    chk("rst pre m_sel", 32'(m_sel), 1);
    reset = 1'b1;
    tick();
    chk("rst rq_done", 32'(rq_done), 0);
    chk("rst rq_error", 32'(rq_error), 0);
    chk("rst rq_rdata", 32'(rq_rdata), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst m_start", 32'(m_start), 0);
    chk("rst m_write", 32'(m_write), 0);
    chk("rst m_sel", 32'(m_sel), 0);
    chk("rst m_addr", 32'(m_addr), 0);
    chk("rst m_wdata", 32'(m_wdata), 0);
    reset = 1'b0;
    rq_req = 2'b00;
    mdl_last = 1'b1;
    run_xfer("rst tie", 2'b11, 2'b00, 2'd1, 2'd1, 8'h05, 8'h06, 8'h00, 8'h00, 0, 0, 0,
             0, 0, mdl_mem[1][5], 2);

    // Random transfers against the transaction model
    for (int it = 0; it < 150; it++) begin
      logic [1:0] req, wr, s0, s1, sw;
      logic [7:0] a0, a1, d0, d1, erd;
      int         wt, lat, r0, r1;
      bit         serr, spur, win, ww, ee;
      req  = 2'($urandom_range(1, 3));
      wr   = 2'($urandom_range(0, 3));
      r0   = $urandom_range(0, 9);
      r1   = $urandom_range(0, 9);
      s0   = (r0 < 8) ? 2'(1 + (r0 % 2)) : ((r0 == 8) ? 2'd0 : 2'd3);
      s1   = (r1 < 8) ? 2'(1 + (r1 % 2)) : ((r1 == 8) ? 2'd0 : 2'd3);
      a0   = 8'($urandom_range(0, 15));
      a1   = 8'($urandom_range(0, 15));
      d0   = 8'($urandom);
      d1   = 8'($urandom);
      wt   = $urandom_range(0, 9);
      serr = ($urandom_range(0, 7) == 0);
      spur = ($urandom_range(0, 3) == 0);
      win  = (req == 2'b01) ? 1'b0 : ((req == 2'b10) ? 1'b1 : ~mdl_last);
      sw   = win ? s1 : s0;
      ww   = win ? wr[1] : wr[0];
      if (sw == 2'd0 || sw == 2'd3) begin
        ee = 1'b1; erd = 8'h00; lat = 0;
      end else if (wt >= T) begin
        ee = 1'b1; erd = 8'h00; lat = T + 1;
      end else begin
        ee  = serr;
        erd = ww ? 8'h00 : mdl_mem[sw][win ? a1 : a0];
        lat = wt + 2;
      end
      run_xfer($sformatf("rnd%0d", it), req, wr, s0, s1, a0, a1, d0, d1, wt, serr, spur,
               win, ee, erd, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
